// File: rtl/timer_pkg.sv
// Shared types and constants for the seconds countdown controller.
package timer_pkg;

  localparam int unsigned BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int unsigned DEF_START_SEC = 60;

  // Tens digit of a 1..99 load value.
  function automatic logic [BCD_W-1:0] start_tens(input int unsigned sec);
    return BCD_W'(sec / 10);
  endfunction

  // Ones digit of a 1..99 load value.
  function automatic logic [BCD_W-1:0] start_ones(input int unsigned sec);
    return BCD_W'(sec % 10);
  endfunction

  localparam logic [BCD_W-1:0] DEF_TENS = start_tens(DEF_START_SEC);
  localparam logic [BCD_W-1:0] DEF_ONES = start_ones(DEF_START_SEC);

endpackage

// File: rtl/bcd_down_counter.sv
// Two-digit BCD down counter with synchronous load; load wins over dec.
module bcd_down_counter
  import timer_pkg::*;
#(
  parameter logic [BCD_W-1:0] LOAD_TENS = DEF_TENS,
  parameter logic [BCD_W-1:0] LOAD_ONES = DEF_ONES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones,
  output logic             is_one
);

  // Digit registers: reload, or borrow from tens when ones is zero.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      tens <= LOAD_TENS;
      ones <= LOAD_ONES;
    end else if (dec) begin
      if (ones != BCD_W'(0)) begin
        ones <= ones - BCD_W'(1);
      end else if (tens != BCD_W'(0)) begin
        ones <= BCD_W'(9);
        tens <= tens - BCD_W'(1);
      end
    end
  end

  // Terminal detect: the next decrement reaches 00.
  always_comb begin
    is_one = (tens == BCD_W'(0)) && (ones == BCD_W'(1));
  end

endmodule

// File: rtl/sec_countdown_ctrl.sv
// Run/pause/clear sequencer with a one-second prescaler and BCD countdown.
module sec_countdown_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 100000000,
  parameter int unsigned START_SEC = 60
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] sec_ones,
  output logic             tick,
  output logic             running,
  output logic             done,
  output logic             done_pulse
);

  localparam int unsigned PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  state_e           state;
  logic [PRE_W-1:0] presc;
  logic             advance;
  logic             wrap;
  logic             cnt_load;
  logic             is_one;

  // The resume cycle in PAUSED counts as a run cycle, so a paused cycle costs exactly one.
  always_comb begin
    advance  = 1'b0;
    wrap     = 1'b0;
    cnt_load = 1'b0;
    if (!clear) begin
      advance = ((state == ST_RUN) && !stop) || ((state == ST_PAUSED) && start);
    end
    wrap     = advance && (presc == PRE_MAX);
    cnt_load = clear || ((state == ST_DONE) && start);
  end

  bcd_down_counter #(
    .LOAD_TENS (start_tens(START_SEC)),
    .LOAD_ONES (start_ones(START_SEC))
  ) u_count (
    .clk    (clk),
    .reset  (reset),
    .load   (cnt_load),
    .dec    (wrap),
    .tens   (sec_tens),
    .ones   (sec_ones),
    .is_one (is_one)
  );

  // State machine, prescaler and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      presc      <= '0;
      tick       <= 1'b0;
      running    <= 1'b0;
      done       <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      tick       <= wrap;
      done_pulse <= 1'b0;
      if (clear) begin
        state   <= ST_IDLE;
        presc   <= '0;
        running <= 1'b0;
        done    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state   <= ST_RUN;
              presc   <= '0;
              running <= 1'b1;
            end
          end
          ST_RUN, ST_PAUSED: begin
            if (state == ST_RUN && stop) begin
              state   <= ST_PAUSED;
              running <= 1'b0;
            end else if (advance) begin
              if (wrap) begin
                presc <= '0;
                if (is_one) begin
                  state      <= ST_DONE;
                  running    <= 1'b0;
                  done       <= 1'b1;
                  done_pulse <= 1'b1;
                end else begin
                  state   <= ST_RUN;
                  running <= 1'b1;
                end
              end else begin
                presc   <= presc + PRE_W'(1);
                state   <= ST_RUN;
                running <= 1'b1;
              end
            end
          end
          ST_DONE: begin
            if (start) begin
              state   <= ST_RUN;
              presc   <= '0;
              running <= 1'b1;
              done    <= 1'b0;
            end
          end
          default: begin
            state   <= ST_IDLE;
            presc   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sec_countdown_ctrl.sv
// Directed bench for sec_countdown_ctrl (4/3 configuration plus a 2/60 borrow instance).
module tb_sec_countdown_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic       start2 = 1'b0;
  logic       stop2 = 1'b0;
  logic       clear2 = 1'b0;
  logic [3:0] sec_tens, sec_ones, sec_tens2, sec_ones2;
  logic       tick, running, done, done_pulse;
  logic       tick2, running2, done2, done_pulse2;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sec_countdown_ctrl #(.TICK_DIV(4), .START_SEC(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .clear      (clear),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .tick       (tick),
    .running    (running),
    .done       (done),
    .done_pulse (done_pulse)
  );

  sec_countdown_ctrl #(.TICK_DIV(2), .START_SEC(60)) dut60 (
    .clk        (clk),
    .reset      (reset),
    .start      (start2),
    .stop       (stop2),
    .clear      (clear2),
    .sec_tens   (sec_tens2),
    .sec_ones   (sec_ones2),
    .tick       (tick2),
    .running    (running2),
    .done       (done2),
    .done_pulse (done_pulse2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int k);
    while (cyc < k) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0; stop = 1'b0; clear = 1'b0;
    start2 = 1'b0; stop2 = 1'b0; clear2 = 1'b0;
    step();
    step();
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic pulse_start_at(input int k);
    goto(k);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    // Reset state of both instances
    do_reset();
    check("rst_flags", {28'd0, tick, running, done, done_pulse}, 32'h0);
    check("rst_cnt", {24'd0, sec_tens, sec_ones}, 32'h03);
    check("rst_cnt60", {24'd0, sec_tens2, sec_ones2}, 32'h60);

    // Full run: start at 10, ticks at 15/19/23, done at 23
    pulse_start_at(10);
    check("run_start", {31'd0, running}, 32'd1);
    for (int c = 11; c <= 24; c++) begin
      goto(c);
      check("run_tick", {31'd0, tick}, (c == 15 || c == 19 || c == 23) ? 32'd1 : 32'd0);
      if (c == 15) check("run_cnt15", {24'd0, sec_tens, sec_ones}, 32'h02);
      if (c == 19) check("run_cnt19", {24'd0, sec_tens, sec_ones}, 32'h01);
      if (c == 23) begin
        check("run_cnt23", {24'd0, sec_tens, sec_ones}, 32'h00);
        check("run_done23", {29'd0, running, done, done_pulse}, 32'b011);
      end
      if (c == 24) check("run_done24", {29'd0, running, done, done_pulse}, 32'b010);
    end

    // Stop is ignored in DONE, start restarts from 03
    goto(25);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("done_stop", {30'd0, running, done}, 32'b01);
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_flags", {29'd0, tick, running, done}, 32'b010);
    check("restart_cnt", {24'd0, sec_tens, sec_ones}, 32'h03);
    goto(30);
    check("restart_tick30", {31'd0, tick}, 32'd0);
    goto(31);
    check("restart_tick31", {31'd0, tick}, 32'd1);
    check("restart_cnt31", {24'd0, sec_tens, sec_ones}, 32'h02);

    // Pause: start 10, stop 13, start 20, first tick at 22
    do_reset();
    pulse_start_at(10);
    for (int c = 11; c <= 22; c++) begin
      goto(c);
      if (c == 13) stop = 1'b1;
      if (c == 14) stop = 1'b0;
      if (c == 20) start = 1'b1;
      if (c == 21) start = 1'b0;
      check("pause_run", {31'd0, running}, (c <= 13 || c >= 21) ? 32'd1 : 32'd0);
      check("pause_tick", {31'd0, tick}, (c == 22) ? 32'd1 : 32'd0);
    end
    check("pause_cnt22", {24'd0, sec_tens, sec_ones}, 32'h02);

    // Stop on the wrap cycle: tick deferred to first RUN cycle after resume
    do_reset();
    pulse_start_at(10);
    goto(14);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("wrapstop_15", {30'd0, tick, running}, 32'b00);
    check("wrapstop_cnt15", {24'd0, sec_tens, sec_ones}, 32'h03);
    goto(18);
    check("wrapstop_18", {30'd0, tick, running}, 32'b00);
    start = 1'b1;
    step();
    start = 1'b0;
    check("wrapstop_19", {30'd0, tick, running}, 32'b11);
    check("wrapstop_cnt19", {24'd0, sec_tens, sec_ones}, 32'h02);

    // clear+stop+start together in RUN at count 01
    do_reset();
    pulse_start_at(10);
    goto(20);
    check("clr_pre_cnt", {24'd0, sec_tens, sec_ones}, 32'h01);
    clear = 1'b1; stop = 1'b1; start = 1'b1;
    step();
    clear = 1'b0; stop = 1'b0; start = 1'b0;
    check("clr_flags", {28'd0, tick, running, done, done_pulse}, 32'h0);
    check("clr_cnt", {24'd0, sec_tens, sec_ones}, 32'h03);
    goto(25);
    check("clr_idle", {29'd0, tick, running, done}, 32'b000);
    check("clr_idle_cnt", {24'd0, sec_tens, sec_ones}, 32'h03);

    // BCD borrow and total run length with TICK_DIV=2, START_SEC=60
    do_reset();
    goto(10);
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    goto(12);
    check("bcd_12", {23'd0, tick2, sec_tens2, sec_ones2}, 32'h060);
    goto(13);
    check("bcd_13", {23'd0, tick2, sec_tens2, sec_ones2}, 32'h159);
    goto(130);
    check("bcd_130", {22'd0, done2, running2, sec_tens2, sec_ones2}, 32'h101);
    goto(131);
    check("bcd_131", {22'd0, done2, running2, sec_tens2, sec_ones2}, 32'h200);
    check("bcd_pulse131", {31'd0, done_pulse2}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sec_countdown_ctrl.md
# sec_countdown_ctrl

Controller that sequences the 60-second timer. It owns a cycle-accurate one-second prescaler, which is gated by a run/pause/clear state machine. It also drives a two-digit BCD seconds countdown. The block sits between the debounced front-panel commands and the display/alarm logic. It replaces free-running derived clocks with a single-cycle `tick` enable in the `clk` domain.

## Interface
- `TICK_DIV`, default 100000000: `clk` cycles per second. Legal range is ≥2.
- `START_SEC`, default 60: countdown load value. Legal range is 1..99.
- `clk` input, 1 bit: system clock. Everything is synchronous to its rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: run command, sampled each cycle.
- `stop` input, 1 bit: pause command.
- `clear` input, 1 bit: abort and reload.
- `sec_tens` output, 4 bits: BCD tens digit of remaining seconds.
- `sec_ones` output, 4 bits: BCD ones digit of remaining seconds.
- `tick` output, 1 bit: one-cycle strobe, asserted in the cycle the count has just decremented.
- `running` output, 1 bit: high while in RUN.
- `done` output, 1 bit: level, high while in DONE.
- `done_pulse` output, 1 bit: one-cycle strobe on entry to DONE.

## Operation
- **States:** IDLE, RUN, PAUSED, DONE.
- **Reset:**
  - State is IDLE.
  - Count is START_SEC (e.g. `sec_tens`=6, `sec_ones`=0).
  - Prescaler is 0.
  - `tick`, `running`, `done`, `done_pulse` are all 0.
- **Command priority within a cycle:** `clear` > `stop` > `start`. Only the highest-priority legal command acts.
- **`clear`, from any state:** go to IDLE, reload START_SEC, zero the prescaler. The next cycle shows `tick`=0.
- **IDLE + `start`:** go to RUN with prescaler 0.
- **RUN + `stop`:** go to PAUSED. The prescaler and count hold, so the partial second is preserved.
- **PAUSED + `start`:** go to RUN. The prescaler resumes from its held value.
- **DONE + `start`:** reload START_SEC, zero the prescaler, go to RUN.
- **Ignored commands:** `stop` in IDLE, PAUSED or DONE; `start` in RUN.
- **Prescaler:** advances only in RUN cycles without `stop`.
  - When it equals TICK_DIV-1, it wraps to 0, the count decrements, and `tick` is registered high for the next cycle.
  - A `stop` on the wrap cycle suppresses the wrap. The prescaler holds at TICK_DIV-1, and the tick fires on the first RUN cycle after resume.
- **BCD decrement:**
  - If ones ≠ 0, ones−1.
  - Otherwise, ones=9 and tens−1.
  - Digits never exceed 9.
- **Terminal count:** a decrement from 01 to 00 moves to DONE in the same edge. `tick`, `done` and `done_pulse` are all high in that cycle; `running` is 0.
- **DONE:** count holds at 00 and the prescaler holds at 0.
- **Outputs:** all outputs are registered; there are no combinational paths from input to output.

## Timing
- **Start to RUN:** `start` sampled in cycle N (IDLE) gives `running`=1 in cycle N+1.
- **First tick:** in cycle N+TICK_DIV+1, with count START_SEC−1.
- **Later ticks:** every TICK_DIV cycles while unpaused.
- **Total run:** `done` rises in cycle N+1+START_SEC·TICK_DIV, provided there are no pauses.
- **Pause accounting:** each paused cycle delays all later ticks by exactly one cycle.
- **`clear` / `reset` latency:** one cycle to take effect.
- **`done_pulse`:** exactly one cycle per completion.
- **`tick` during a pause:** never asserted in PAUSED, IDLE or DONE, except on the DONE-entry cycle.

## Structure
- **Package `timer_pkg`:**
  - State enum (IDLE, RUN, PAUSED, DONE).
  - BCD digit width constant (4).
  - Digit constants derived from START_SEC (START_SEC/10 and START_SEC%10).
- **Sub-module `bcd_down_counter`:**
  - Inputs: `load` and `dec`.
  - Outputs: two BCD digits and a combinational `is_one` flag, used for terminal detect.
  - `load` has priority over `dec`.
- **Top level:** the FSM, the prescaler and the output registers.

## Test plan
All scenarios use TICK_DIV=4 and START_SEC=3 unless noted.
- **Reset then `start` pulse at cycle 10:**
  - `running`=1 at cycle 11.
  - `tick` at cycles 15, 19, 23, with count 02, 01, 00.
  - `done`=1 and `done_pulse`=1 at cycle 23, then `done_pulse`=0 at 24.
- **Pause:** `start` at 10, `stop` at 13, `start` at 20. The first tick moves from 15 to 22, so `running` is low for cycles 14–20.
- **`stop` on the wrap cycle:** `stop` asserted in cycle 14 (prescaler=3). No tick at 15; the tick comes on the first RUN cycle after resume, with count 02.
- **Simultaneous `clear`+`stop`+`start` in RUN with count 01:**
  - Next cycle: IDLE, count 03, `running`=0, no tick.
- **Restart from DONE:** `start` in DONE reloads 03, and `done` falls the next cycle.
- **BCD borrow:** START_SEC=60, TICK_DIV=2. After the first tick, `sec_tens`=5 and `sec_ones`=9. `done` is reached after exactly 120 RUN cycles.
